// File: rtl/fir_guide_core.sv
// 16-tap symmetric FIR (pre-add / multiply / sum pipeline) with a 3-cycle sample-to-output latency.
// Define FIR_SIGNED_EN to treat xin as two's complement; by default all arithmetic is unsigned.
module fir_guide_core (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [11:0] xin,
    output logic        valid,
    output logic [28:0] yout
);

`ifdef FIR_SIGNED_EN
    typedef logic signed [11:0] samp_t;
    typedef logic signed [12:0] pre_t;
    typedef logic signed [24:0] prod_t;
    typedef logic signed [28:0] acc_t;
`else
    typedef logic [11:0] samp_t;
    typedef logic [12:0] pre_t;
    typedef logic [24:0] prod_t;
    typedef logic [28:0] acc_t;
`endif

    localparam int NTAP  = 16;
    localparam int NHALF = 8;

    // Only the first half is stored; c[15-k] = c[k] is exploited by the pre-adders.
    localparam logic [11:0] C_COEF [NHALF] = '{
        12'd11, 12'd31, 12'd63, 12'd104, 12'd152, 12'd198, 12'd235, 12'd255
    };

    samp_t      r_x [NTAP];
    prod_t      w_prod [NHALF];
    logic [2:0] r_en_d;
    logic       r_valid;
    acc_t       r_y;
    acc_t       w_sum;

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NTAP; i++) begin
                r_x[i] <= '0;
            end
        end else if (en) begin
            r_x[0] <= samp_t'(xin);
            for (int i = 1; i < NTAP; i++) begin
                r_x[i] <= r_x[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NHALF; gi++) begin : g_tap
            localparam prod_t COEF = prod_t'(C_COEF[gi]);
            pre_t  r_pre;
            prod_t r_prod;
            pre_t  w_pre;

            // Casting before the add widens each operand with its own signedness.
            assign w_pre = pre_t'(r_x[gi]) + pre_t'(r_x[NTAP-1-gi]);

            always_ff @(posedge clk) begin
                if (rstn) begin
                    r_pre  <= '0;
                    r_prod <= '0;
                end else begin
                    r_pre  <= w_pre;
                    r_prod <= prod_t'(r_pre) * COEF;
                end
            end

            assign w_prod[gi] = r_prod;
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NHALF; k++) begin
            w_sum = w_sum + acc_t'(w_prod[k]);
        end
    end

    // r_en_d[2] marks the product stage as holding a captured sample; valid follows the yout load.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_en_d  <= '0;
            r_valid <= 1'b0;
            r_y     <= '0;
        end else begin
            r_en_d  <= {r_en_d[1:0], en};
            r_valid <= r_en_d[2];
            if (r_en_d[2]) begin
                r_y <= w_sum;
            end
        end
    end

    assign valid = r_valid;
    assign yout  = r_y;

endmodule

// File: tb/tb_fir_guide_core.sv
// Directed-vector bench for fir_guide_core: impulse, DC, latency, en gaps and mid-stream reset.
`timescale 1ns/1ps
module tb_fir_guide_core;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [11:0] xin;
    logic        valid;
    logic [28:0] yout;

    int n_checks = 0;
    int n_errors = 0;

    int imp_exp [17] = '{11, 31, 63, 104, 152, 198, 235, 255,
                         255, 235, 198, 152, 104, 63, 31, 11, 0};

    fir_guide_core dut (
        .clk   (clk),
        .rstn  (rstn),
        .en    (en),
        .xin   (xin),
        .valid (valid),
        .yout  (yout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [28:0] got, input logic [28:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    // One clock edge with the given reset/en/sample; returns 1 ns after the edge.
    task automatic step(input logic r, input logic e, input logic [11:0] x);
        @(negedge clk);
        rstn = r;
        en   = e;
        xin  = x;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b1;
        en   = 1'b0;
        xin  = '0;
        step(1'b1, 1'b0, 12'd0);
        step(1'b1, 1'b1, 12'd77);
        check("reset_valid", 29'(valid), 29'd0);
        check("reset_yout", yout, 29'd0);
        step(1'b0, 1'b0, 12'd0);

`ifdef FIR_SIGNED_EN
        step(1'b0, 1'b1, 12'hFFF);
        step(1'b0, 1'b1, 12'd0);
        step(1'b0, 1'b1, 12'd0);
        step(1'b0, 1'b1, 12'd0);
        check("simp_0", yout, 29'h1FFFFFF5);
        check("simp_0_valid", 29'(valid), 29'd1);
        step(1'b0, 1'b1, 12'd0);
        check("simp_1", yout, 29'h1FFFFFE1);
        step(1'b0, 1'b1, 12'd0);
        check("simp_2", yout, 29'h1FFFFFC1);
`else
        // Impulse, also covering the first-result latency.
        step(1'b0, 1'b1, 12'd1);
        check("lat_k0_valid", 29'(valid), 29'd0);
        step(1'b0, 1'b1, 12'd0);
        check("lat_k1_valid", 29'(valid), 29'd0);
        step(1'b0, 1'b1, 12'd0);
        check("lat_k2_valid", 29'(valid), 29'd0);
        check("lat_k2_yout", yout, 29'd0);
        for (int j = 0; j < 17; j++) begin
            step(1'b0, 1'b1, 12'd0);
            check($sformatf("imp_%0d", j), yout, 29'(imp_exp[j]));
            check($sformatf("imp_%0d_valid", j), 29'(valid), 29'd1);
        end

        // DC ramp from an all-zero history up to the full tap sum.
        for (int j = 0; j < 22; j++) begin
            step(1'b0, 1'b1, 12'd4095);
            if (j == 2)  check("dc_2", yout, 29'd0);
            if (j == 3)  check("dc_3", yout, 29'd45045);
            if (j == 4)  check("dc_4", yout, 29'd171990);
            if (j == 17) check("dc_17", yout, 29'd8546265);
            if (j >= 18) check($sformatf("dc_%0d", j), yout, 29'd8591310);
        end

        // Reset for one edge mid-run, with en still high.
        step(1'b1, 1'b1, 12'd4095);
        check("mrst_yout", yout, 29'd0);
        check("mrst_valid", 29'(valid), 29'd0);
        for (int j = 0; j < 5; j++) begin
            step(1'b0, 1'b1, 12'd4095);
            if (j < 3) begin
                check($sformatf("mrst_r%0d_valid", j), 29'(valid), 29'd0);
                check($sformatf("mrst_r%0d_yout", j), yout, 29'd0);
            end
            if (j == 3) check("mrst_r3_yout", yout, 29'd45045);
            if (j == 3) check("mrst_r3_valid", 29'(valid), 29'd1);
            if (j == 4) check("mrst_r4_yout", yout, 29'd171990);
        end

        // en gap pattern 1,1,0,1 with distinct samples; 999 must never enter.
        step(1'b1, 1'b0, 12'd0);
        step(1'b1, 1'b0, 12'd0);
        step(1'b0, 1'b0, 12'd0);
        step(1'b0, 1'b1, 12'd100);
        step(1'b0, 1'b1, 12'd200);
        step(1'b0, 1'b0, 12'd999);
        check("gap_e2_valid", 29'(valid), 29'd0);
        step(1'b0, 1'b1, 12'd300);
        check("gap_e3_yout", yout, 29'd1100);
        check("gap_e3_valid", 29'(valid), 29'd1);
        step(1'b0, 1'b0, 12'd0);
        check("gap_e4_yout", yout, 29'd5300);
        check("gap_e4_valid", 29'(valid), 29'd1);
        step(1'b0, 1'b0, 12'd0);
        check("gap_e5_yout", yout, 29'd5300);
        check("gap_e5_valid", 29'(valid), 29'd0);
        step(1'b0, 1'b0, 12'd0);
        check("gap_e6_yout", yout, 29'd15800);
        check("gap_e6_valid", 29'(valid), 29'd1);
        step(1'b0, 1'b0, 12'd0);
        check("gap_e7_yout", yout, 29'd15800);
        check("gap_e7_valid", 29'(valid), 29'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
